// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session controller: FSM states, operation
// codes, result codes and an op-validity helper.
package atm_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOOKUP = 2'd1;
    localparam state_t ST_EXEC   = 2'd2;
    localparam state_t ST_MENU   = 2'd3;

    localparam logic [2:0] OP_LOGIN    = 3'd0;
    localparam logic [2:0] OP_LOGOUT   = 3'd1;
    localparam logic [2:0] OP_BALANCE  = 3'd3;
    localparam logic [2:0] OP_WITHDRAW = 3'd4;
    localparam logic [2:0] OP_TRANSFER = 3'd6;
    localparam logic [2:0] OP_DEPOSIT  = 3'd7;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_AUTH      = 3'd1;
    localparam logic [2:0] ERR_FUNDS     = 3'd2;
    localparam logic [2:0] ERR_NODEST    = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW  = 3'd4;
    localparam logic [2:0] ERR_LOCKED    = 3'd5;
    localparam logic [2:0] ERR_NOSESSION = 3'd6;
    localparam logic [2:0] ERR_BADOP     = 3'd7;

    function automatic logic op_defined(input logic [2:0] op);
        return (op == OP_LOGIN)    || (op == OP_LOGOUT)   || (op == OP_BALANCE) ||
               (op == OP_WITHDRAW) || (op == OP_TRANSFER) || (op == OP_DEPOSIT);
    endfunction

endpackage

// File: rtl/atm_account_lookup.sv
// Combinational account-number to index match plus PIN compare.
// Account i is numbered ACC_BASE+i and has PIN i mod 2^PIN_W.
module atm_account_lookup #(
    parameter int NUM_ACCOUNTS = 10,
    parameter int ACC_W        = 12,
    parameter int PIN_W        = 4,
    parameter int ACC_BASE     = 2100,
    parameter int IDX_W        = 4
) (
    input  logic [ACC_W-1:0] acc_num_i,
    input  logic [PIN_W-1:0] pin_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             pin_ok_o
);

    always_comb begin
        hit_o    = 1'b0;
        idx_o    = '0;
        pin_ok_o = 1'b0;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (acc_num_i == ACC_W'(ACC_BASE + i)) begin
                hit_o    = 1'b1;
                idx_o    = IDX_W'(i);
                pin_ok_o = (pin_i == PIN_W'(i));
            end
        end
    end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: balance store, login session, one request per
// handshake. Optional PIN lockout is compiled in with ATM_LOCKOUT_EN.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int NUM_ACCOUNTS = 10,
    parameter int ACC_W        = 12,
    parameter int PIN_W        = 4,
    parameter int BAL_W        = 16,
    parameter int AMT_W        = 11,
    parameter int ACC_BASE     = 2100,
    parameter int INIT_BALANCE = 500,
    parameter int MAX_TRIES    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exit,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [ACC_W-1:0] acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic [ACC_W-1:0] dest_acc,
    input  logic [AMT_W-1:0] amount,
    output logic             rsp_valid,
    output logic [2:0]       rsp_code,
    output logic [BAL_W-1:0] balance,
    output logic             logged_in,
    output logic [1:0]       dbg_state
);

    localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
    localparam int EXT_W = BAL_W + 1;
    localparam logic [EXT_W-1:0] BAL_LIMIT = {1'b0, {BAL_W{1'b1}}};

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high and exit is low; inputs are sampled only then.
    state_t             state_q, state_d;
    logic [2:0]         op_q;
    logic [ACC_W-1:0]   acc_q, dest_q;
    logic [PIN_W-1:0]   pin_q;
    logic [AMT_W-1:0]   amt_q;
    logic               src_hit_q, src_pin_ok_q, dst_hit_q;
    logic [IDX_W-1:0]   src_idx_q, dst_idx_q;
    logic               sess_q;
    logic [IDX_W-1:0]   sess_idx_q;
    logic [BAL_W-1:0]   bal_q [NUM_ACCOUNTS];
    logic               rsp_valid_q;
    logic [2:0]         rsp_code_q;
    logic [BAL_W-1:0]   rsp_bal_q;

    logic               src_hit, src_pin_ok, dst_hit, unused_dst_pin_ok;
    logic [IDX_W-1:0]   src_idx, dst_idx;
    logic               accept, exec_fire, src_locked;

    logic [2:0]         ex_code;
    logic [BAL_W-1:0]   ex_bal, src_new, dst_new, cur_bal, dst_bal;
    logic               ex_sess, wr_src, wr_dst, fail_inc, fail_clr;
    logic [IDX_W-1:0]   ex_idx;
    logic [EXT_W-1:0]   amt_ext, dep_sum, xfer_sum;

    assign req_ready = (state_q == ST_IDLE) || (state_q == ST_MENU);
    assign accept    = req_valid && req_ready && !exit;
    assign exec_fire = (state_q == ST_EXEC) && !exit;

    atm_account_lookup #(
        .NUM_ACCOUNTS(NUM_ACCOUNTS), .ACC_W(ACC_W), .PIN_W(PIN_W),
        .ACC_BASE(ACC_BASE), .IDX_W(IDX_W)
    ) u_src_lookup (
        .acc_num_i(acc_q), .pin_i(pin_q),
        .hit_o(src_hit), .idx_o(src_idx), .pin_ok_o(src_pin_ok)
    );

    atm_account_lookup #(
        .NUM_ACCOUNTS(NUM_ACCOUNTS), .ACC_W(ACC_W), .PIN_W(PIN_W),
        .ACC_BASE(ACC_BASE), .IDX_W(IDX_W)
    ) u_dst_lookup (
        .acc_num_i(dest_q), .pin_i(pin_q),
        .hit_o(dst_hit), .idx_o(dst_idx), .pin_ok_o(unused_dst_pin_ok)
    );

    assign cur_bal  = bal_q[sess_idx_q];
    assign dst_bal  = bal_q[dst_idx_q];
    assign amt_ext  = EXT_W'(amt_q);
    assign dep_sum  = {1'b0, cur_bal} + amt_ext;
    assign xfer_sum = {1'b0, dst_bal} + amt_ext;

    always_comb begin
        ex_code  = ERR_NONE;
        ex_bal   = sess_q ? cur_bal : '0;
        ex_sess  = sess_q;
        ex_idx   = sess_idx_q;
        wr_src   = 1'b0;
        wr_dst   = 1'b0;
        src_new  = cur_bal;
        dst_new  = dst_bal;
        fail_inc = 1'b0;
        fail_clr = 1'b0;
        if (!op_defined(op_q)) begin
            ex_code = ERR_BADOP;
        end else if (!sess_q) begin
            if (op_q != OP_LOGIN) begin
                ex_code = ERR_NOSESSION;
            end else if (!src_hit_q) begin
                ex_code = ERR_AUTH;
            end else if (src_locked) begin
                ex_code = ERR_LOCKED;
            end else if (!src_pin_ok_q) begin
                ex_code  = ERR_AUTH;
                fail_inc = 1'b1;
            end else begin
                ex_sess  = 1'b1;
                ex_idx   = src_idx_q;
                ex_bal   = bal_q[src_idx_q];
                fail_clr = 1'b1;
            end
        end else begin
            case (op_q)
                OP_LOGOUT:  ex_sess = 1'b0;
                OP_BALANCE: ex_code = ERR_NONE;
                OP_WITHDRAW: begin
                    if (amt_ext > {1'b0, cur_bal}) begin
                        ex_code = ERR_FUNDS;
                    end else begin
                        wr_src  = 1'b1;
                        src_new = BAL_W'({1'b0, cur_bal} - amt_ext);
                        ex_bal  = src_new;
                    end
                end
                OP_DEPOSIT: begin
                    if (dep_sum > BAL_LIMIT) begin
                        ex_code = ERR_OVERFLOW;
                    end else begin
                        wr_src  = 1'b1;
                        src_new = dep_sum[BAL_W-1:0];
                        ex_bal  = src_new;
                    end
                end
                OP_TRANSFER: begin
                    if (!dst_hit_q || (dst_idx_q == sess_idx_q)) begin
                        ex_code = ERR_NODEST;
                    end else if (amt_ext > {1'b0, cur_bal}) begin
                        ex_code = ERR_FUNDS;
                    end else if (xfer_sum > BAL_LIMIT) begin
                        ex_code = ERR_OVERFLOW;
                    end else begin
                        wr_src  = 1'b1;
                        wr_dst  = 1'b1;
                        src_new = BAL_W'({1'b0, cur_bal} - amt_ext);
                        dst_new = xfer_sum[BAL_W-1:0];
                        ex_bal  = src_new;
                    end
                end
                default: ex_code = ERR_BADOP;
            endcase
        end
    end

`ifdef ATM_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    logic [FAIL_W-1:0] fail_q [NUM_ACCOUNTS];

    assign src_locked = (fail_q[src_idx_q] >= FAIL_W'(MAX_TRIES));

    // Increments happen only while unlocked, so the counter saturates at MAX_TRIES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) fail_q[i] <= '0;
        end else if (exec_fire && fail_inc) begin
            fail_q[src_idx_q] <= fail_q[src_idx_q] + 1'b1;
        end else if (exec_fire && fail_clr) begin
            fail_q[src_idx_q] <= '0;
        end
    end
`else
    logic unused_lockout;
    assign src_locked     = 1'b0;
    assign unused_lockout = fail_inc | fail_clr | (MAX_TRIES != 0);
`endif

    always_comb begin
        state_d = state_q;
        if (exit) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_MENU: if (req_valid) state_d = ST_LOOKUP;
                ST_LOOKUP:        state_d = ST_EXEC;
                ST_EXEC:          state_d = ex_sess ? ST_MENU : ST_IDLE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            acc_q        <= '0;
            dest_q       <= '0;
            pin_q        <= '0;
            amt_q        <= '0;
            src_hit_q    <= 1'b0;
            src_pin_ok_q <= 1'b0;
            src_idx_q    <= '0;
            dst_hit_q    <= 1'b0;
            dst_idx_q    <= '0;
            sess_q       <= 1'b0;
            sess_idx_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_code_q   <= ERR_NONE;
            rsp_bal_q    <= '0;
            for (int i = 0; i < NUM_ACCOUNTS; i++) bal_q[i] <= BAL_W'(INIT_BALANCE);
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= exec_fire;
            if (accept) begin
                op_q   <= req_op;
                acc_q  <= acc_num;
                dest_q <= dest_acc;
                pin_q  <= pin;
                amt_q  <= amount;
            end
            if (state_q == ST_LOOKUP) begin
                src_hit_q    <= src_hit;
                src_pin_ok_q <= src_pin_ok;
                src_idx_q    <= src_idx;
                dst_hit_q    <= dst_hit;
                dst_idx_q    <= dst_idx;
            end
            // exit wins over a completing request: no response, no store write.
            if (exit) begin
                sess_q <= 1'b0;
            end else if (exec_fire) begin
                sess_q     <= ex_sess;
                sess_idx_q <= ex_idx;
                rsp_code_q <= ex_code;
                rsp_bal_q  <= ex_bal;
                if (wr_src) bal_q[sess_idx_q] <= src_new;
                if (wr_dst) bal_q[dst_idx_q]  <= dst_new;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_code  = rsp_code_q;
    assign balance   = rsp_bal_q;
    assign logged_in = sess_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Self-checking bench for atm_session_ctrl (default build and ATM_LOCKOUT_EN build).
module tb_atm_session_ctrl;
  import atm_pkg::*;

  localparam int NACC    = 10;
  localparam int BASE    = 2100;
  localparam int BAL_MAX = 65535;
  localparam int TRIES   = 3;
`ifdef ATM_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic        exit_s = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [11:0] acc_num = '0;
  logic [3:0]  pin = '0;
  logic [11:0] dest_acc = '0;
  logic [10:0] amount = '0;

  logic        req_ready, rsp_valid, logged_in;
  logic [2:0]  rsp_code;
  logic [15:0] balance;
  logic [1:0]  dbg_state;

  logic        s_req_ready, s_rsp_valid, s_logged_in;
  logic [2:0]  s_rsp_code;
  logic [10:0] s_balance;
  logic [1:0]  s_dbg_state;

  atm_session_ctrl dut (
    .clk(clk), .rst_n(rst_n), .exit(exit_s), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .acc_num(acc_num), .pin(pin), .dest_acc(dest_acc), .amount(amount),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code), .balance(balance), .logged_in(logged_in),
    .dbg_state(dbg_state)
  );

  atm_session_ctrl #(.BAL_W(11), .AMT_W(11)) dut_small (
    .clk(clk), .rst_n(rst_n), .exit(exit_s), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_op(req_op), .acc_num(acc_num), .pin(pin), .dest_acc(dest_acc), .amount(amount),
    .rsp_valid(s_rsp_valid), .rsp_code(s_rsp_code), .balance(s_balance), .logged_in(s_logged_in),
    .dbg_state(s_dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int rsp_cnt = 0;

  always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: balances and lock counters as plain integers
  int m_bal[NACC];
  int m_fail[NACC];
  bit m_sess;
  int m_idx;

  function automatic void model_reset();
    for (int i = 0; i < NACC; i++) begin
      m_bal[i] = 500;
      m_fail[i] = 0;
    end
    m_sess = 1'b0;
    m_idx = 0;
  endfunction

  function automatic void model_apply(input int op, input logic [11:0] acc, input logic [3:0] p,
                                      input logic [11:0] dst, input int amt,
                                      output int code, output int bal);
    int a, d;
    a = int'(acc) - BASE;
    d = int'(dst) - BASE;
    code = 0;
    bal = m_sess ? m_bal[m_idx] : 0;
    if (!(op == 0 || op == 1 || op == 3 || op == 4 || op == 6 || op == 7)) begin
      code = 7;
    end else if (!m_sess) begin
      if (op != 0) code = 6;
      else if (a < 0 || a >= NACC) code = 1;
      else if (LOCK_EN && m_fail[a] >= TRIES) code = 5;
      else if (int'(p) != a % 16) begin
        code = 1;
        if (m_fail[a] < TRIES) m_fail[a]++;
      end else begin
        m_sess = 1'b1;
        m_idx = a;
        m_fail[a] = 0;
        bal = m_bal[a];
      end
    end else begin
      case (op)
        0: code = 7;
        1: m_sess = 1'b0;
        4: if (amt > m_bal[m_idx]) code = 2; else m_bal[m_idx] -= amt;
        7: if (m_bal[m_idx] + amt > BAL_MAX) code = 4; else m_bal[m_idx] += amt;
        6: begin
          if (d < 0 || d >= NACC || d == m_idx) code = 3;
          else if (amt > m_bal[m_idx]) code = 2;
          else if (m_bal[d] + amt > BAL_MAX) code = 4;
          else begin
            m_bal[m_idx] -= amt;
            m_bal[d] += amt;
          end
        end
        default: ;
      endcase
      if (m_sess || op == 1) bal = m_bal[m_idx];
    end
  endfunction

  // driver tasks (called at a falling edge)
  task automatic send(input logic [2:0] op, input logic [11:0] acc, input logic [3:0] p,
                      input logic [11:0] dst, input logic [10:0] amt);
    int k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_req", req_ready, 1);
    req_op = op; acc_num = acc; pin = p; dest_acc = dst; amount = amt;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 3'($urandom); acc_num = 12'($urandom); pin = 4'($urandom);
    dest_acc = 12'($urandom); amount = 11'($urandom);
  endtask

  task automatic do_req(input string name, input logic [2:0] op, input logic [11:0] acc,
                        input logic [3:0] p, input logic [11:0] dst, input logic [10:0] amt,
                        input logic [2:0] e_code, input int e_bal, input bit e_lg,
                        input bit chk_s, input logic [2:0] e_scode, input int e_sbal);
    send(op, acc, p, dst, amt);
    check({name, ".no_rsp_n1"}, rsp_valid, 0);
    check({name, ".busy"}, req_ready, 0);
    @(posedge clk); @(negedge clk);
    check({name, ".no_rsp_n2"}, rsp_valid, 0);
    @(posedge clk); @(negedge clk);
    check({name, ".rsp_valid"}, rsp_valid, 1);
    check({name, ".code"}, rsp_code, e_code);
    check({name, ".balance"}, balance, e_bal);
    check({name, ".logged_in"}, logged_in, e_lg);
    check({name, ".ready"}, req_ready, 1);
    if (chk_s) begin
      check({name, ".s_rsp_valid"}, s_rsp_valid, 1);
      check({name, ".s_code"}, s_rsp_code, e_scode);
      check({name, ".s_balance"}, s_balance, e_sbal);
    end
    @(posedge clk); @(negedge clk);
    check({name, ".strobe_1cyc"}, rsp_valid, 0);
    check({name, ".code_hold"}, rsp_code, e_code);
  endtask

  task automatic req(input string name, input logic [2:0] op, input logic [11:0] acc,
                     input logic [3:0] p, input logic [11:0] dst, input logic [10:0] amt,
                     input logic [2:0] e_code, input int e_bal, input bit e_lg);
    do_req(name, op, acc, p, dst, amt, e_code, e_bal, e_lg, 1'b0, 3'd0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; exit_s = 1'b0; req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [11:0] acc;
    logic [3:0]  p;
    logic [11:0] dst;
    logic [10:0] amt;
    logic [2:0]  code;
    int          bal;
    bit          lg;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [2:0] op, input int acc, input int p, input int dst,
                              input int amt, input logic [2:0] code, input int bal, input bit lg);
    vec_t v;
    v.op = op; v.acc = 12'(acc); v.p = 4'(p); v.dst = 12'(dst); v.amt = 11'(amt);
    v.code = code; v.bal = bal; v.lg = lg;
    tbl.push_back(v);
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, e_code, e_bal;
    logic [2:0] op;
    logic [11:0] acc, dst;
    logic [3:0] p;
    logic [10:0] amt;

    // reset state
    do_reset();
    check("reset.req_ready", req_ready, 1);
    check("reset.rsp_valid", rsp_valid, 0);
    check("reset.rsp_code", rsp_code, ERR_NONE);
    check("reset.balance", balance, 0);
    check("reset.logged_in", logged_in, 0);
    check("reset.state", dbg_state, ST_IDLE);

    // directed table
    add(OP_LOGIN,    2103, 3, 0,    0,   ERR_NONE,      500,  1);
    add(OP_BALANCE,  0,    0, 0,    0,   ERR_NONE,      500,  1);
    add(OP_WITHDRAW, 0,    0, 0,    600, ERR_FUNDS,     500,  1);
    add(OP_WITHDRAW, 0,    0, 0,    200, ERR_NONE,      300,  1);
    add(OP_TRANSFER, 0,    0, 2105, 100, ERR_NONE,      200,  1);
    add(OP_TRANSFER, 0,    0, 9999, 10,  ERR_NODEST,    200,  1);
    add(OP_TRANSFER, 0,    0, 2103, 10,  ERR_NODEST,    200,  1);
    add(OP_TRANSFER, 0,    0, 2104, 300, ERR_FUNDS,     200,  1);
    add(OP_WITHDRAW, 0,    0, 0,    0,   ERR_NONE,      200,  1);
    add(OP_DEPOSIT,  0,    0, 0,    50,  ERR_NONE,      250,  1);
    add(OP_LOGIN,    2100, 0, 0,    0,   ERR_BADOP,     250,  1);
    add(3'd2,        0,    0, 0,    0,   ERR_BADOP,     250,  1);
    add(OP_LOGOUT,   0,    0, 0,    0,   ERR_NONE,      250,  0);
    add(OP_BALANCE,  0,    0, 0,    0,   ERR_NOSESSION, 0,    0);
    add(OP_LOGIN,    9999, 0, 0,    0,   ERR_AUTH,      0,    0);
    add(OP_LOGIN,    2105, 5, 0,    0,   ERR_NONE,      600,  1);
    add(OP_BALANCE,  0,    0, 0,    0,   ERR_NONE,      600,  1);
    add(OP_WITHDRAW, 0,    0, 0,    600, ERR_NONE,      0,    1);
    add(OP_WITHDRAW, 0,    0, 0,    1,   ERR_FUNDS,     0,    1);
    add(OP_LOGOUT,   0,    0, 0,    0,   ERR_NONE,      0,    0);
    add(OP_LOGIN,    2109, 9, 0,    0,   ERR_NONE,      500,  1);
    add(OP_TRANSFER, 0,    0, 2110, 1,   ERR_NODEST,    500,  1);
    add(OP_TRANSFER, 0,    0, 2100, 500, ERR_NONE,      0,    1);
    add(OP_LOGOUT,   0,    0, 0,    0,   ERR_NONE,      0,    0);
    add(OP_LOGIN,    2100, 0, 0,    0,   ERR_NONE,      1000, 1);
    add(OP_LOGOUT,   0,    0, 0,    0,   ERR_NONE,      1000, 0);
    for (int i = 0; i < tbl.size(); i++)
      req($sformatf("tbl[%0d]", i), tbl[i].op, tbl[i].acc, tbl[i].p, tbl[i].dst, tbl[i].amt,
          tbl[i].code, tbl[i].bal, tbl[i].lg);

    // overflow boundaries: 16-bit and 11-bit balance instances side by side
    do_reset();
    do_req("ovf.login", OP_LOGIN, 12'd2100, 4'd0, 12'd0, 11'd0, ERR_NONE, 500, 1, 1, ERR_NONE, 500);
    check("ovf.s_logged_in", s_logged_in, 1);
    check("ovf.s_state", s_dbg_state, ST_MENU);
    do_req("ovf.dep1600", OP_DEPOSIT, 12'd0, 4'd0, 12'd0, 11'd1600, ERR_NONE, 2100, 1, 1, ERR_OVERFLOW, 500);
    do_req("ovf.dep1547", OP_DEPOSIT, 12'd0, 4'd0, 12'd0, 11'd1547, ERR_NONE, 3647, 1, 1, ERR_NONE, 2047);
    do_req("ovf.dep1", OP_DEPOSIT, 12'd0, 4'd0, 12'd0, 11'd1, ERR_NONE, 3648, 1, 1, ERR_OVERFLOW, 2047);
    do_req("ovf.dep0", OP_DEPOSIT, 12'd0, 4'd0, 12'd0, 11'd0, ERR_NONE, 3648, 1, 1, ERR_NONE, 2047);
    do_req("ovf.logout", OP_LOGOUT, 12'd0, 4'd0, 12'd0, 11'd0, ERR_NONE, 3648, 0, 1, ERR_NONE, 2047);
    do_req("ovf.login1", OP_LOGIN, 12'd2101, 4'd1, 12'd0, 11'd0, ERR_NONE, 500, 1, 1, ERR_NONE, 500);
    do_req("ovf.xfer", OP_TRANSFER, 12'd0, 4'd0, 12'd2100, 11'd1, ERR_NONE, 499, 1, 1, ERR_OVERFLOW, 500);
    check("ovf.s_ready", s_req_ready, 1);
    do_req("ovf.nosess", OP_LOGOUT, 12'd0, 4'd0, 12'd0, 11'd0, ERR_NONE, 499, 0, 1, ERR_NONE, 500);
    req("ovf.bal_idle", OP_BALANCE, 12'd0, 4'd0, 12'd0, 11'd0, ERR_NOSESSION, 0, 0);

    // PIN lockout
    do_reset();
    for (int i = 0; i < 3; i++)
      req($sformatf("lock.bad%0d", i), OP_LOGIN, 12'd2101, 4'd0, 12'd0, 11'd0, ERR_AUTH, 0, 0);
`ifdef ATM_LOCKOUT_EN
    req("lock.good_pin", OP_LOGIN, 12'd2101, 4'd1, 12'd0, 11'd0, ERR_LOCKED, 0, 0);
    req("lock.again", OP_LOGIN, 12'd2101, 4'd1, 12'd0, 11'd0, ERR_LOCKED, 0, 0);
`else
    req("lock.good_pin", OP_LOGIN, 12'd2101, 4'd1, 12'd0, 11'd0, ERR_NONE, 500, 1);
    req("lock.logout", OP_LOGOUT, 12'd0, 4'd0, 12'd0, 11'd0, ERR_NONE, 500, 0);
`endif
    for (int r = 0; r < 2; r++) begin
      req($sformatf("clr%0d.bad0", r), OP_LOGIN, 12'd2102, 4'd0, 12'd0, 11'd0, ERR_AUTH, 0, 0);
      req($sformatf("clr%0d.bad1", r), OP_LOGIN, 12'd2102, 4'd0, 12'd0, 11'd0, ERR_AUTH, 0, 0);
      req($sformatf("clr%0d.good", r), OP_LOGIN, 12'd2102, 4'd2, 12'd0, 11'd0, ERR_NONE, 500, 1);
      req($sformatf("clr%0d.out", r), OP_LOGOUT, 12'd0, 4'd0, 12'd0, 11'd0, ERR_NONE, 500, 0);
    end

    // exit during LOOKUP aborts the withdraw
    do_reset();
    req("exit.login", OP_LOGIN, 12'd2103, 4'd3, 12'd0, 11'd0, ERR_NONE, 500, 1);
    snap = rsp_cnt;
    send(OP_WITHDRAW, 12'd0, 4'd0, 12'd0, 11'd100);
    exit_s = 1'b1;
    @(posedge clk); @(negedge clk);
    exit_s = 1'b0;
    check("exit1.logged_in", logged_in, 0);
    check("exit1.state", dbg_state, ST_IDLE);
    check("exit1.ready", req_ready, 1);
    repeat (3) @(negedge clk);
    check("exit1.no_rsp", rsp_cnt - snap, 0);
    req("exit1.relogin", OP_LOGIN, 12'd2103, 4'd3, 12'd0, 11'd0, ERR_NONE, 500, 1);

    // exit during EXEC aborts the withdraw
    snap = rsp_cnt;
    send(OP_WITHDRAW, 12'd0, 4'd0, 12'd0, 11'd100);
    @(posedge clk); @(negedge clk);
    exit_s = 1'b1;
    @(posedge clk); @(negedge clk);
    exit_s = 1'b0;
    check("exit2.rsp_valid", rsp_valid, 0);
    check("exit2.logged_in", logged_in, 0);
    repeat (3) @(negedge clk);
    check("exit2.no_rsp", rsp_cnt - snap, 0);
    req("exit2.relogin", OP_LOGIN, 12'd2103, 4'd3, 12'd0, 11'd0, ERR_NONE, 500, 1);

    // exit with a request offered in the same cycle: not accepted
    snap = rsp_cnt;
    req_op = OP_BALANCE; req_valid = 1'b1; exit_s = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; exit_s = 1'b0;
    check("exit3.state", dbg_state, ST_IDLE);
    check("exit3.logged_in", logged_in, 0);
    repeat (3) @(negedge clk);
    check("exit3.no_rsp", rsp_cnt - snap, 0);

    // reset asserted mid-request
    req("rst.login", OP_LOGIN, 12'd2103, 4'd3, 12'd0, 11'd0, ERR_NONE, 500, 1);
    send(OP_WITHDRAW, 12'd0, 4'd0, 12'd0, 11'd100);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    snap = rsp_cnt;
    @(negedge clk);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.logged_in", logged_in, 0);
    check("rst.balance", balance, 0);
    check("rst.code", rsp_code, ERR_NONE);
    repeat (3) @(negedge clk);
    check("rst.no_rsp", rsp_cnt - snap, 0);
    req("rst.relogin", OP_LOGIN, 12'd2103, 4'd3, 12'd0, 11'd0, ERR_NONE, 500, 1);

    // randomized traffic against the model
    do_reset();
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        exit_s = 1'b1;
        @(posedge clk); @(negedge clk);
        exit_s = 1'b0;
        m_sess = 1'b0;
        check($sformatf("rnd%0d.exit", it), logged_in, 0);
        continue;
      end
      op = 3'($urandom_range(0, 7));
      if (!m_sess && $urandom_range(0, 3) != 0) op = OP_LOGIN;
      acc = 12'(2098 + $urandom_range(0, 13));
      p = ($urandom_range(0, 9) < 7) ? 4'(int'(acc) - BASE) : 4'($urandom);
      dst = ($urandom_range(0, 9) == 0) ? 12'd4000 : 12'(2098 + $urandom_range(0, 13));
      amt = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 400));
      model_apply(int'(op), acc, p, dst, int'(amt), e_code, e_bal);
      req($sformatf("rnd%0d", it), op, acc, p, dst, amt, 3'(e_code), e_bal, m_sess);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
